// File: rtl/la_acq_if.sv
// AXI4-Stream bundle carrying DN lanes of type DT per beat.
interface axi4_stream_if #(
  parameter int unsigned DN = 2,
  parameter type         DT = logic [8-1:0]
);
  DT [DN-1:0]    TDATA;
  logic [DN-1:0] TKEEP;
  logic          TLAST;
  logic          TVALID;
  logic          TREADY;

  modport master (output TDATA, TKEEP, TLAST, TVALID, input TREADY);
  modport slave  (input TDATA, TKEEP, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/la_acq.sv
// Logic-analyzer acquisition control: pre-trigger fill, armed wait, post-trigger
// capture, with one registered AXI4-Stream output stage.
module la_acq #(
  parameter int unsigned DN = 2,
  parameter type         DT = logic [8-1:0],
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ctl_rst,
  input  logic          ctl_acq,
  input  logic          ctl_stp,
  input  logic          ctl_trg,
  input  logic          trg,
  input  logic [CW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_pst,
  output logic          sts_acq,
  output logic          sts_trg,
  output logic [CW-1:0] sts_pre,
  output logic [CW-1:0] sts_pst,
  axi4_stream_if.slave  sti,
  axi4_stream_if.master sto
);

  typedef enum logic [1:0] {IDL, PRE, ARM, PST} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pre_nxt, pst_nxt;
  logic          trg_nxt;
  logic          pend, pend_nxt;
  logic          vld, vld_nxt;
  logic          last, last_nxt;
  logic          load, fin, beat, ready_c;
  DT [DN-1:0]    data;
  logic [DN-1:0] keep;

  // Idle swallows input; active states only accept when the output slot frees up.
  assign ready_c    = (state == IDL) | ~vld | sto.TREADY;
  assign sti.TREADY = ready_c;
  assign beat       = sti.TVALID & ready_c;

  assign sto.TVALID = vld;
  assign sto.TLAST  = last;
  assign sto.TDATA  = data;
  assign sto.TKEEP  = keep;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pre_nxt   = sts_pre;
    pst_nxt   = sts_pst;
    trg_nxt   = sts_trg;
    pend_nxt  = pend;
    vld_nxt   = vld & ~sto.TREADY;
    last_nxt  = last;
    load      = 1'b0;
    fin       = 1'b0;
    if (ctl_rst) begin
      state_nxt = IDL;
      pre_nxt   = '0;
      pst_nxt   = '0;
      trg_nxt   = 1'b0;
      pend_nxt  = 1'b0;
      vld_nxt   = 1'b0;
    end else begin
      case (state)
        IDL: if (ctl_acq) begin
          state_nxt = (cfg_pre == '0) ? ARM : PRE;
          pre_nxt   = '0;
          pst_nxt   = '0;
          trg_nxt   = 1'b0;
          pend_nxt  = 1'b0;
        end
        PRE: if (beat) begin
          load    = 1'b1;
          pre_nxt = sts_pre + CW'(1);
          if (pre_nxt == cfg_pre) state_nxt = ARM;
        end
        ARM: begin
          if (beat) begin
            load    = 1'b1;
            pre_nxt = (&sts_pre) ? sts_pre : sts_pre + CW'(1);
          end
          // A beat coinciding with the trigger is itself the trigger beat.
          if (beat && (trg || ctl_trg)) begin
            trg_nxt = 1'b1;
            if (cfg_pst == '0) begin
              fin       = 1'b1;
              state_nxt = IDL;
            end else begin
              state_nxt = PST;
            end
          end else if (ctl_trg) begin
            trg_nxt   = 1'b1;
            pend_nxt  = 1'b1;
            state_nxt = PST;
          end
        end
        PST: if (beat) begin
          load = 1'b1;
          if (pend) begin
            pend_nxt = 1'b0;
            fin      = (cfg_pst == '0);
          end else begin
            pst_nxt = sts_pst + CW'(1);
            fin     = (pst_nxt == cfg_pst);
          end
          if (fin) state_nxt = IDL;
        end
        default: state_nxt = IDL;
      endcase
      if (load) begin
        vld_nxt  = 1'b1;
        last_nxt = fin;
      end
      // Stop closes the capture on whatever beat is left in the output slot.
      if (ctl_stp && state != IDL) begin
        state_nxt = IDL;
        pend_nxt  = 1'b0;
        last_nxt  = 1'b1;
      end
    end
    if (!vld_nxt) last_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sts_pre <= '0;
      sts_pst <= '0;
      sts_trg <= 1'b0;
      sts_acq <= 1'b0;
      pend    <= 1'b0;
      vld     <= 1'b0;
      last    <= 1'b0;
    end else begin
      sts_pre <= pre_nxt;
      sts_pst <= pst_nxt;
      sts_trg <= trg_nxt;
      sts_acq <= (state_nxt != IDL);
      pend    <= pend_nxt;
      vld     <= vld_nxt;
      last    <= last_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data <= '0;
      keep <= '0;
    end else if (load) begin
      data <= sti.TDATA;
      keep <= sti.TKEEP;
    end
  end

endmodule

// File: tb/tb_la_acq.sv
// Directed bench for la_acq: capture windows, backpressure, stop, soft reset, async reset.
module tb_la_acq;
  localparam int unsigned DN = 2;
  localparam int unsigned CW = 32;
  typedef logic [7:0] lane_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ctl_rst, ctl_acq, ctl_stp, ctl_trg, trg;
  logic [CW-1:0] cfg_pre, cfg_pst;
  logic          sts_acq, sts_trg;
  logic [CW-1:0] sts_pre, sts_pst;

  axi4_stream_if #(.DN(DN), .DT(lane_t)) sti_if ();
  axi4_stream_if #(.DN(DN), .DT(lane_t)) sto_if ();

  la_acq #(.DN(DN), .DT(lane_t), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .ctl_rst(ctl_rst), .ctl_acq(ctl_acq), .ctl_stp(ctl_stp),
    .ctl_trg(ctl_trg), .trg(trg), .cfg_pre(cfg_pre), .cfg_pst(cfg_pst),
    .sts_acq(sts_acq), .sts_trg(sts_trg), .sts_pre(sts_pre), .sts_pst(sts_pst),
    .sti(sti_if), .sto(sto_if)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fails  = 0;
  int            stab_err = 0;
  logic          stab_en  = 1'b0;
  logic          rdy_rand = 1'b0;
  logic          prev_hold = 1'b0;
  logic [17:0]   prev_pl = '0;
  logic [31:0]   got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input lane_t v, input logic l);
    logic [1:0] k;
    k = v[0] ? 2'b01 : 2'b11;
    return {13'd0, l, k, ~v, v};
  endfunction

  function automatic logic [31:0] out_word();
    return {13'd0, sto_if.TLAST, sto_if.TKEEP, sto_if.TDATA};
  endfunction

  // Output collector plus hold-stability and stall-cause monitor.
  always @(negedge clk) begin
    if (sto_if.TVALID && sto_if.TREADY) got_q.push_back(out_word());
    if (stab_en) begin
      if (prev_hold && !(sto_if.TVALID && {sto_if.TKEEP, sto_if.TDATA} == prev_pl)) stab_err++;
      if (sti_if.TVALID && !sti_if.TREADY && !(sto_if.TVALID && !sto_if.TREADY)) stab_err++;
    end
    prev_hold = sto_if.TVALID & ~sto_if.TREADY;
    prev_pl   = {sto_if.TKEEP, sto_if.TDATA};
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) sto_if.TREADY = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input lane_t v, input logic t);
    int n;
    n = 0;
    sti_if.TVALID = 1'b1;
    sti_if.TDATA  = {~v, v};
    sti_if.TKEEP  = v[0] ? 2'b01 : 2'b11;
    sti_if.TLAST  = v[1];
    trg           = t;
    @(negedge clk);
    while (!sti_if.TREADY && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(n), 32'd0);
    step();
    sti_if.TVALID = 1'b0;
    trg           = 1'b0;
  endtask

  task automatic send_ramp(input int n, input int ta, input int tb);
    for (int i = 0; i < n; i++) send(8'(i), (i == ta) || (i == tb));
  endtask

  task automatic check_seq(input string tag, input int n);
    check($sformatf("%s_len", tag), 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), got_q[i], exp_word(8'(i), i == n - 1));
  endtask

  task automatic start(input int pre, input int pst);
    got_q.delete();
    cfg_pre = CW'(pre);
    cfg_pst = CW'(pst);
    ctl_acq = 1'b1;
    step();
    ctl_acq = 1'b0;
  endtask

  task automatic pulse_stp();
    ctl_stp = 1'b1;
    step();
    ctl_stp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; ctl_rst = 1'b0; ctl_acq = 1'b0; ctl_stp = 1'b0; ctl_trg = 1'b0; trg = 1'b0;
    cfg_pre = '0; cfg_pst = '0;
    sti_if.TVALID = 1'b0; sti_if.TDATA = '0; sti_if.TKEEP = '0; sti_if.TLAST = 1'b0;
    sto_if.TREADY = 1'b1;
    repeat (3) step();
    check("rst_tvalid", 32'(sto_if.TVALID), 32'd0);
    check("rst_tlast", 32'(sto_if.TLAST), 32'd0);
    check("rst_acq", 32'(sts_acq), 32'd0);
    check("rst_pre", sts_pre, 32'd0);
    rstn = 1'b1;
    step();
    check("post_rst_tready", 32'(sti_if.TREADY), 32'd1);
    got_q.delete();
    send(8'h55, 1'b1);
    send(8'h56, 1'b0);
    step();
    check("idle_no_fwd", 32'(got_q.size()), 32'd0);

    // Basic window, sink always ready.
    start(4, 3);
    check("acq_sts", 32'(sts_acq), 32'd1);
    send_ramp(16, 8, -1);
    repeat (3) step();
    check_seq("ramp", 12);
    check("ramp_pre", sts_pre, 32'd9);
    check("ramp_pst", sts_pst, 32'd3);
    check("ramp_trg", 32'(sts_trg), 32'd1);
    check("ramp_acq", 32'(sts_acq), 32'd0);

    // Same window under random backpressure.
    stab_err = 0;
    stab_en  = 1'b1;
    rdy_rand = 1'b1;
    start(4, 3);
    send_ramp(16, 8, -1);
    rdy_rand = 1'b0;
    sto_if.TREADY = 1'b1;
    repeat (3) step();
    stab_en = 1'b0;
    check_seq("bp", 12);
    check("bp_stability", 32'(stab_err), 32'd0);
    check("bp_pre", sts_pre, 32'd9);

    // Trigger during pre-fill is ignored.
    start(4, 3);
    send_ramp(16, 2, 9);
    repeat (3) step();
    check_seq("pretrg", 13);
    check("pretrg_pre", sts_pre, 32'd10);
    check("pretrg_pst", sts_pst, 32'd3);

    // Zero pre and post: trigger beat alone is the capture.
    start(0, 0);
    send_ramp(4, 0, -1);
    repeat (3) step();
    check_seq("zero", 1);
    check("zero_trg", 32'(sts_trg), 32'd1);
    check("zero_acq", 32'(sts_acq), 32'd0);
    check("zero_pst", sts_pst, 32'd0);

    // Software trigger: next beat is the uncounted trigger beat.
    start(1, 1);
    send(8'd0, 1'b0);
    send(8'd1, 1'b0);
    ctl_trg = 1'b1;
    step();
    ctl_trg = 1'b0;
    check("swtrg_trg", 32'(sts_trg), 32'd1);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    repeat (3) step();
    check_seq("swtrg", 4);
    check("swtrg_pst", sts_pst, 32'd1);
    check("swtrg_pre", sts_pre, 32'd2);

    // Stop while the sink stalls with value 6 held.
    start(2, 5);
    send_ramp(7, -1, -1);
    sto_if.TREADY = 1'b0;
    pulse_stp();
    check("stp_acq", 32'(sts_acq), 32'd0);
    check("stp_held", out_word(), {13'd0, 1'b1, 2'b11, ~8'd6, 8'd6});
    check("stp_tvalid", 32'(sto_if.TVALID), 32'd1);
    send(8'd7, 1'b1);
    send(8'd8, 1'b0);
    sto_if.TREADY = 1'b1;
    repeat (3) step();
    check_seq("stp", 7);

    // Software reset empties the output slot.
    start(3, 3);
    sto_if.TREADY = 1'b0;
    send(8'd0, 1'b0);
    check("srst_pre_before", sts_pre, 32'd1);
    ctl_rst = 1'b1;
    step();
    ctl_rst = 1'b0;
    check("srst_tvalid", 32'(sto_if.TVALID), 32'd0);
    check("srst_pre", sts_pre, 32'd0);
    check("srst_acq", 32'(sts_acq), 32'd0);
    sto_if.TREADY = 1'b1;
    repeat (2) step();
    check("srst_no_out", 32'(got_q.size()), 32'd0);

    // Async reset mid post-trigger with a beat held.
    start(1, 4);
    send(8'd0, 1'b0);
    send(8'd1, 1'b1);
    send(8'd2, 1'b0);
    sto_if.TREADY = 1'b0;
    check("ar_pst_before", sts_pst, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_tvalid", 32'(sto_if.TVALID), 32'd0);
    check("ar_tlast", 32'(sto_if.TLAST), 32'd0);
    check("ar_acq", 32'(sts_acq), 32'd0);
    check("ar_trg", 32'(sts_trg), 32'd0);
    check("ar_pre", sts_pre, 32'd0);
    check("ar_pst", sts_pst, 32'd0);
    step();
    rstn = 1'b1;
    sto_if.TREADY = 1'b1;
    step();
    check("ar_tready", 32'(sti_if.TREADY), 32'd1);
    start(2, 1);
    send(8'd10, 1'b0);
    check("ar_restart_pre", sts_pre, 32'd1);
    check("ar_restart_acq", 32'(sts_acq), 32'd1);
    check("ar_restart_trg", 32'(sts_trg), 32'd0);
    pulse_stp();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/la_acq.md
LA_ACQ -- requirements
Module: la_acq

Interface
REQ-001 Parameter DN, default 2, number of data lanes per stream beat.
REQ-002 Parameter DT, default logic [8-1:0], lane data type.
REQ-003 Parameter CW, default 32, width of the pre-trigger and post-trigger counters.
REQ-004 Port clk  input  1  clock; both stream interfaces are synchronous to it.
REQ-005 Port rstn  input  1  reset, asynchronous and active-low.
REQ-006 Port ctl_rst  input  1  synchronous software reset of the FSM, counters and output register.
REQ-007 Port ctl_acq  input  1  start-acquisition pulse.
REQ-008 Port ctl_stp  input  1  stop-acquisition pulse.
REQ-009 Port ctl_trg  input  1  software trigger pulse.
REQ-010 Port trg  input  1  hardware trigger, aligned with the sti beat it qualifies (driven from la_trg sts_trg OR-reduced).
REQ-011 Port cfg_pre  input  CW  required pre-trigger beat count.
REQ-012 Port cfg_pst  input  CW  post-trigger beat count after the trigger beat.
REQ-013 Port sts_acq  output  1  high while in PRE, ARM or PST.
REQ-014 Port sts_trg  output  1  high from trigger acceptance until the next ctl_acq, ctl_rst or reset.
REQ-015 Port sts_pre  output  CW  pre-trigger beats counted.
REQ-016 Port sts_pst  output  CW  post-trigger beats counted.
REQ-017 Port sti  slave  axi4_stream_if #(DN,DT)  input stream (TDATA, TKEEP, TLAST, TVALID, TREADY).
REQ-018 Port sto  master  axi4_stream_if #(DN,DT)  output stream.

Function
REQ-019 Beat = sti.TVALID & sti.TREADY; all counting, triggering and state transitions key on beats only.
REQ-020 FSM states: IDL, PRE, ARM, PST; encoding is free.
REQ-021 IDL: sti.TREADY=1, beats discarded, sto.TVALID=0; ctl_acq -> PRE, sts_pre/sts_pst/sts_trg cleared.
REQ-022 PRE: each beat forwarded, sts_pre+1; when post-increment sts_pre==cfg_pre -> ARM; cfg_pre=0 -> ARM on the cycle after ctl_acq; triggers ignored in PRE.
REQ-023 ARM: each beat forwarded, sts_pre+1 saturating at 2^CW-1; trigger event = (trg & beat) | ctl_trg -> PST, sts_trg=1.
REQ-024 Trigger beat: the beat carrying trg, or the next beat after ctl_trg; it is not counted in sts_pst.
REQ-025 PST: each beat after the trigger beat forwarded, sts_pst+1; beat with post-increment sts_pst==cfg_pst -> IDL.
REQ-026 Final beat: the trigger beat when cfg_pst=0, else the cfg_pst-th post-trigger beat; it is output with sto.TLAST=1; all other forwarded beats have TLAST=0 regardless of sti.TLAST.
REQ-027 Datapath: one register stage, latency exactly 1 cycle from sti beat to sto.TVALID; TDATA and TKEEP unchanged.
REQ-028 Active states: sti.TREADY = ~sto.TVALID | sto.TREADY; no beat lost or duplicated under backpressure.
REQ-029 sto.TVALID stays high with stable payload until sto.TREADY.
REQ-030 ctl_stp in PRE/ARM/PST -> IDL next cycle; a beat held in the output register is still delivered, TLAST forced to 1; if empty, no extra beat.
REQ-031 Priority when simultaneous: ctl_rst > ctl_stp > ctl_acq; ctl_acq outside IDL ignored; ctl_trg outside ARM ignored.
REQ-032 ctl_rst: next cycle state IDL, counters and sts_trg 0, output register emptied (sto.TVALID=0).
REQ-033 Trigger coincident with the beat completing PRE is ignored.

Reset
REQ-034 rstn low asynchronously sets: state IDL, sto.TVALID=0, sto.TLAST=0, sts_acq=0, sts_trg=0, sts_pre=0, sts_pst=0.
REQ-035 sti.TREADY=1 and outputs stable one cycle after rstn deasserts; no beat forwarded before ctl_acq.

Verification
REQ-036 cfg_pre=4, cfg_pst=3, ramp 0..15, trg on value 8, sto always ready -> sto carries 0..11, TLAST on 11, sts_pre=9, sts_pst=3.
REQ-037 Same as REQ-036 with sto.TREADY random 50% -> identical sto sequence, no gaps in data, sti stalls only while output held.
REQ-038 cfg_pre=4, trg on value 2 and 9 -> trigger at 2 ignored, trigger at 9 accepted, TLAST on 12.
REQ-039 cfg_pre=0, cfg_pst=0, ctl_acq then trg on first beat value 0 -> single beat 0 with TLAST=1, sts_trg=1, return to IDL.
REQ-040 ctl_stp during ARM after value 6 accepted, sto stalled -> value 6 delivered with TLAST=1, sts_acq=0, later beats discarded.
REQ-041 rstn asserted mid-PST with sto.TVALID=1 -> all outputs at REQ-034 values immediately, next ctl_acq restarts counts from 0.
